// File: rtl/spike_decoder_pkg.sv
// Shared constants and state types for the spike winner decoder.
// Optional build macro: SPIKE_DECODER_EDGE_EN (edge-counting channels).
package spike_decoder_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 8;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN,
    HOLD
  } scan_st_e;

  typedef enum logic {
    T_IDLE,
    T_COUNT
  } win_st_e;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/spike_channel_counter.sv
// One channel's saturating spike counter, cleared at window end.
// SPIKE_DECODER_EDGE_EN: count only rising edges of the spike input.
module spike_channel_counter
  import spike_decoder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_cnt_en,
  input  logic             i_win_end,
  input  logic             i_spike,
  output logic [CNT_W-1:0] o_next
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic             w_hit;
  logic [CNT_W-1:0] r_cnt;

`ifdef SPIKE_DECODER_EDGE_EN
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_prev <= 1'b0;
    else if (i_clr)
      r_prev <= 1'b0;
    else
      r_prev <= i_spike;
  end

  assign w_hit = i_spike & ~r_prev;
`else
  assign w_hit = i_spike;
`endif

  // Value including this cycle's spike; the top snapshots it at window end.
  assign o_next = (w_hit && r_cnt != MAX) ? r_cnt + CNT_W'(1) : r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_cnt_en)
      r_cnt <= i_win_end ? '0 : o_next;
  end

endmodule

// File: rtl/spike_winner_decoder.sv
// Windowed spike counting, winner scan and valid/ready result delivery.
// Optional build macro: SPIKE_DECODER_EDGE_EN (edge-counting channels).
module spike_winner_decoder
  import spike_decoder_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_CH-1:0]  spike_in,
  input  logic [WIN_W-1:0] win_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_tie,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

  win_st_e          r_wst, w_wst_nxt;
  scan_st_e         r_sst, w_sst_nxt;
  logic             w_counting;
  logic [WIN_W-1:0] r_wcnt, r_len, w_len;
  logic             w_win_end, w_free, w_snap;
  logic [CNT_W-1:0] w_next   [N_CH];
  logic [CNT_W-1:0] r_shadow [N_CH];
  logic [IDX_W-1:0] r_sidx, r_idx;
  logic [CNT_W-1:0] r_cnt, w_cur;
  logic             r_tie, r_ovr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_wst <= T_IDLE;
    else
      r_wst <= w_wst_nxt;
  end

  always_comb begin
    w_wst_nxt = r_wst;
    unique case (r_wst)
      T_IDLE:  w_wst_nxt = enable ? T_COUNT : T_IDLE;
      T_COUNT: w_wst_nxt = enable ? T_COUNT : T_IDLE;
      default: w_wst_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    w_counting = (r_wst == T_COUNT) && enable;
  end

  // Window length is live only on the first cycle, then held.
  assign w_len = (r_wcnt == '0) ?
                 ((win_len == '0) ? WIN_W'(1) : win_len) : r_len;
  assign w_win_end = w_counting && (r_wcnt == w_len - WIN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wcnt <= '0;
      r_len  <= '0;
    end else if (!enable) begin
      r_wcnt <= '0;
    end else if (w_counting) begin
      r_wcnt <= w_win_end ? '0 : r_wcnt + WIN_W'(1);
      if (r_wcnt == '0)
        r_len <= w_len;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    spike_channel_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (~enable),
      .i_cnt_en  (w_counting),
      .i_win_end (w_win_end),
      .i_spike   (spike_in[g]),
      .o_next    (w_next[g])
    );
  end

  assign w_free = (r_sst == SCAN_IDLE) || ((r_sst == HOLD) && out_ready);
  assign w_snap = w_win_end && w_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++)
        r_shadow[i] <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_snap)
        for (int i = 0; i < N_CH; i++)
          r_shadow[i] <= w_next[i];
      if (w_win_end && !w_free)
        r_ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_sst <= SCAN_IDLE;
    else
      r_sst <= w_sst_nxt;
  end

  always_comb begin
    w_sst_nxt = r_sst;
    unique case (r_sst)
      SCAN_IDLE: w_sst_nxt = w_snap ? SCAN : SCAN_IDLE;
      SCAN:      w_sst_nxt = (r_sidx == LAST) ? HOLD : SCAN;
      HOLD: begin
        if (out_ready)
          w_sst_nxt = w_snap ? SCAN : SCAN_IDLE;
      end
      default:   w_sst_nxt = SCAN_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_sst == HOLD);
  end

  assign w_cur = r_shadow[r_sidx];

  // Strict greater-than keeps the lowest index among equal maxima.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sidx <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_tie  <= 1'b0;
    end else if (w_snap) begin
      r_sidx <= '0;
    end else if (r_sst == SCAN) begin
      r_sidx <= r_sidx + IDX_W'(1);
      if (r_sidx == '0) begin
        r_idx <= '0;
        r_cnt <= w_cur;
        r_tie <= 1'b0;
      end else if (w_cur > r_cnt) begin
        r_idx <= r_sidx;
        r_cnt <= w_cur;
        r_tie <= 1'b0;
      end else if (w_cur == r_cnt) begin
        r_tie <= 1'b1;
      end
    end
  end

  assign out_idx   = r_idx;
  assign out_count = r_cnt;
  assign out_tie   = r_tie;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_spike_winner_decoder.sv
// Bench for spike_winner_decoder: window-level reference model plus
// directed scenarios with literal expectations and randomized traffic.
module tb_spike_winner_decoder;

  localparam int N = 4;
`ifdef SPIKE_DECODER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] spike_in = '0;
  logic [7:0] win_len = 8'd8;

  logic       out_valid, out_tie, overrun;
  logic [1:0] out_idx;
  logic [7:0] out_count;

  logic       q_valid, q_tie, q_ovr;
  logic [1:0] q_idx;
  logic [3:0] q_count;

  spike_winner_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .spike_in  (spike_in),
    .win_len   (win_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_tie   (out_tie),
    .overrun   (overrun)
  );

  spike_winner_decoder #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .spike_in  (spike_in),
    .win_len   (win_len),
    .out_valid (q_valid),
    .out_ready (out_ready),
    .out_idx   (q_idx),
    .out_count (q_count),
    .out_tie   (q_tie),
    .overrun   (q_ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model: per-window spike tallies, argmax, and an output
  // slot that is busy from snapshot until the result is accepted.
  bit m_act;
  int m_pos, m_L;
  int m_c[N];
  bit m_prev[N];
  bit m_have, m_ovr, m_rtie;
  int m_vat, m_ecnt, m_ridx, m_rcnt;
  bit wend, hold, acc, hit;
  int bi, bc, nt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 0; m_pos = 0; m_L = 1;
      for (int i = 0; i < N; i++) begin
        m_c[i] = 0; m_prev[i] = 0;
      end
      m_have = 0; m_ovr = 0; m_vat = 0; m_ecnt = 0;
      m_ridx = 0; m_rcnt = 0; m_rtie = 0;
    end else begin
      wend = 0;
      m_ecnt++;
      hold = m_have && (m_ecnt > m_vat);
      acc = hold && out_ready;
      if (!enable) begin
        m_act = 0; m_pos = 0;
        for (int i = 0; i < N; i++) begin
          m_c[i] = 0; m_prev[i] = 0;
        end
      end else begin
        if (m_act) begin
          if (m_pos == 0)
            m_L = (win_len == 0) ? 1 : int'(win_len);
          for (int i = 0; i < N; i++) begin
            hit = spike_in[i] && !(EDGE && m_prev[i]);
            if (hit && m_c[i] < 255) m_c[i]++;
          end
          m_pos++;
          if (m_pos == m_L) begin
            wend = 1;
            bi = 0; bc = -1; nt = 0;
            for (int i = 0; i < N; i++)
              if (m_c[i] > bc) begin bc = m_c[i]; bi = i; end
            for (int i = 0; i < N; i++)
              if (m_c[i] == bc) nt++;
            for (int i = 0; i < N; i++) m_c[i] = 0;
            m_pos = 0;
          end
        end
        m_act = 1;
        for (int i = 0; i < N; i++) m_prev[i] = spike_in[i];
      end
      if (wend) begin
        if (!m_have || acc) begin
          m_have = 1; m_vat = m_ecnt + N;
          m_ridx = bi; m_rcnt = bc; m_rtie = (nt > 1);
        end else begin
          m_ovr = 1;
        end
      end else if (acc) begin
        m_have = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = m_have && (m_ecnt >= m_vat);
    chk("model_valid", out_valid, ev);
    chk("model_overrun", overrun, m_ovr);
    if (ev) begin
      chk("model_idx", out_idx, m_ridx);
      chk("model_count", out_count, m_rcnt);
      chk("model_tie", out_tie, m_rtie);
    end
  end

  always @(posedge clk)
    if (!reset && out_valid && out_ready) n_xfer++;

  logic [3:0] pat [64];

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    enable = 1'b0;
    spike_in = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_en();
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic play(input int n);
    for (int c = 0; c < n; c++) begin
      spike_in = pat[c];
      @(negedge clk);
    end
    spike_in = '0;
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 80) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s timeout: out_valid=%b want 1", nm, out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_count", out_count, 0);
    chk("rst_tie", out_tie, 0);
    chk("rst_overrun", overrun, 0);
    #1 reset = 1'b0;
    @(negedge clk);

    // Channel 2 held high for a whole 8-cycle window.
    do_reset();
    win_len = 8'd8;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) pat[c] = 4'b0100;
    start_en();
    play(8);
    repeat (3) @(negedge clk);
    chk("t1_latency_early", out_valid, 0);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_idx", out_idx, 2);
    chk("t1_count", out_count, EDGE ? 1 : 8);
    chk("t1_tie", out_tie, 0);

    // The following silent window reports all-zero with a tie.
    @(negedge clk);
    wait_valid("t3_wait");
    chk("t3_idx", out_idx, 0);
    chk("t3_count", out_count, 0);
    chk("t3_tie", out_tie, 1);

    // Channels 1 and 3 five pulses each, channel 0 three.
    do_reset();
    win_len = 8'd16;
    for (int c = 0; c < 16; c++) begin
      pat[c] = '0;
      pat[c][1] = (c < 10) && (c % 2 == 0);
      pat[c][3] = (c < 10) && (c % 2 == 1);
      pat[c][0] = (c >= 10) && (c % 2 == 0);
    end
    start_en();
    play(16);
    wait_valid("t2_wait");
    chk("t2_idx", out_idx, 1);
    chk("t2_count", out_count, 5);
    chk("t2_tie", out_tie, 1);

    // 20 spikes on channel 0 in a 32-cycle window; 4-bit copy saturates.
    do_reset();
    win_len = 8'd32;
    for (int c = 0; c < 32; c++) pat[c] = (c < 20) ? 4'b0001 : 4'b0000;
    start_en();
    play(32);
    wait_valid("t4_wait");
    chk("t4_count8", out_count, EDGE ? 1 : 20);
    chk("t4_idx8", out_idx, 0);
    chk("t4_valid4", q_valid, 1);
    chk("t4_count4", q_count, EDGE ? 1 : 15);
    chk("t4_idx4", q_idx, 0);
    chk("t4_tie4", q_tie, 0);
    chk("t4_ovr4", q_ovr, 0);

    // Backpressure across two window ends: second result is dropped.
    do_reset();
    out_ready = 1'b0;
    win_len = 8'd5;
    for (int c = 0; c < 10; c++) pat[c] = 4'b0100;
    start_en();
    play(10);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_valid", out_valid, 1);
    chk("t5_idx", out_idx, 2);
    chk("t5_count", out_count, EDGE ? 1 : 5);
    chk("t5_overrun", overrun, 1);
    n_xfer = 0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_valid_after", out_valid, 0);
    chk("t5_xfers", n_xfer, 1);
    chk("t5_overrun_sticky", overrun, 1);

    // Reset while scanning, then a clean window.
    do_reset();
    out_ready = 1'b1;
    win_len = 8'd6;
    for (int c = 0; c < 6; c++) pat[c] = (c % 2 == 0) ? 4'b0001 : 4'b0000;
    start_en();
    play(6);
    @(negedge clk);
    #1 reset = 1'b1;
    enable = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_idx", out_idx, 0);
    chk("t6_count", out_count, 0);
    chk("t6_tie", out_tie, 0);
    chk("t6_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    win_len = 8'd8;
    for (int c = 0; c < 8; c++) pat[c] = (c % 2 == 0) ? 4'b0010 : 4'b0000;
    start_en();
    play(8);
    wait_valid("t6b_wait");
    chk("t6b_idx", out_idx, 1);
    chk("t6b_count", out_count, 4);
    chk("t6b_tie", out_tie, 0);

    // Randomized traffic against the model.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      spike_in = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        win_len = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 299) == 0)
        enable = ~enable;
      @(negedge clk);
    end
    spike_in = '0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
